// File: rtl/sound_pkg.sv
// sound_pkg: shared types and tables for the sound sequencer.
//   - event_e : event IDs in priority order (0 = highest), EV_NONE = idle marker
//   - state_e : sequencer phases IDLE / NOTE / GAP
//   - TONE_*  : note codes understood by the tone generator (0 = silence)
//   - note_len / note_tone : per-event jingle length and note lookup (max 4 notes)
package sound_pkg;

    typedef enum logic [2:0] {
        EV_HOLE   = 3'd0,
        EV_BALL   = 3'd1,
        EV_BORDER = 3'd2,
        EV_ENTER  = 3'd3,
        EV_KEYY   = 3'd4,
        EV_KEYX   = 3'd5,
        EV_NONE   = 3'd7
    } event_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int NUM_EVENTS = 6;

    localparam logic [3:0] TONE_SILENCE = 4'd0;
    localparam logic [3:0] TONE_C4      = 4'd1;
    localparam logic [3:0] TONE_D4      = 4'd2;
    localparam logic [3:0] TONE_E4      = 4'd3;
    localparam logic [3:0] TONE_G4      = 4'd4;
    localparam logic [3:0] TONE_A4      = 4'd5;
    localparam logic [3:0] TONE_B4      = 4'd6;
    localparam logic [3:0] TONE_C5      = 4'd7;
    localparam logic [3:0] TONE_D5      = 4'd8;
    localparam logic [3:0] TONE_E5      = 4'd9;
    localparam logic [3:0] TONE_G5      = 4'd10;
    localparam logic [3:0] TONE_C6      = 4'd11;

    // Number of notes in each event's jingle.
    function automatic logic [2:0] note_len(input event_e ev);
        case (ev)
            EV_HOLE:   note_len = 3'd4;
            EV_BALL:   note_len = 3'd2;
            EV_BORDER: note_len = 3'd1;
            EV_ENTER:  note_len = 3'd3;
            EV_KEYY:   note_len = 3'd1;
            EV_KEYX:   note_len = 3'd1;
            default:   note_len = 3'd0;
        endcase
    endfunction

    // Note code for position ptr of an event's jingle; silence outside the table.
    function automatic logic [3:0] note_tone(input event_e ev, input logic [1:0] ptr);
        logic [3:0] t;
        t = TONE_SILENCE;
        case (ev)
            EV_HOLE: begin
                case (ptr)
                    2'd0:    t = TONE_C5;
                    2'd1:    t = TONE_E5;
                    2'd2:    t = TONE_G5;
                    2'd3:    t = TONE_C6;
                    default: t = TONE_SILENCE;
                endcase
            end
            EV_BALL: begin
                case (ptr)
                    2'd0:    t = TONE_A4;
                    2'd1:    t = TONE_E5;
                    default: t = TONE_SILENCE;
                endcase
            end
            EV_BORDER: t = (ptr == 2'd0) ? TONE_C4 : TONE_SILENCE;
            EV_ENTER: begin
                case (ptr)
                    2'd0:    t = TONE_G4;
                    2'd1:    t = TONE_B4;
                    2'd2:    t = TONE_D5;
                    default: t = TONE_SILENCE;
                endcase
            end
            EV_KEYY:   t = (ptr == 2'd0) ? TONE_E4 : TONE_SILENCE;
            EV_KEYX:   t = (ptr == 2'd0) ? TONE_D4 : TONE_SILENCE;
            default:   t = TONE_SILENCE;
        endcase
        note_tone = t;
    endfunction

endpackage

// File: rtl/sound_req_latch.sv
// sound_req_latch: rising-edge detection, pending bits and priority encoding
// of the six sound requests.
//   clk, reset   : clock, synchronous active-high reset
//   req_i        : raw request lines, bit index = event ID
//   clr_i        : clear the pending bit of clr_id_i (event being loaded)
//   clr_id_i     : event whose pending bit is cleared
//   win_valid_o  : at least one event is pending
//   win_id_o     : highest-priority pending event (EV_NONE when none)
module sound_req_latch
    import sound_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] req_i,
    input  logic                  clr_i,
    input  event_e                clr_id_i,
    output logic                  win_valid_o,
    output event_e                win_id_o
);

    logic [NUM_EVENTS-1:0] req_q;
    logic [NUM_EVENTS-1:0] req_d;
    logic [NUM_EVENTS-1:0] pending_q;
    logic [NUM_EVENTS-1:0] pending_d;
    logic [NUM_EVENTS-1:0] clr_mask;

    // Decode the clear request into a one-hot mask.
    always_comb begin
        clr_mask = {NUM_EVENTS{1'b0}};
        if (clr_i) begin
            case (clr_id_i)
                EV_HOLE:   clr_mask[0] = 1'b1;
                EV_BALL:   clr_mask[1] = 1'b1;
                EV_BORDER: clr_mask[2] = 1'b1;
                EV_ENTER:  clr_mask[3] = 1'b1;
                EV_KEYY:   clr_mask[4] = 1'b1;
                EV_KEYX:   clr_mask[5] = 1'b1;
                default:   clr_mask = {NUM_EVENTS{1'b0}};
            endcase
        end else begin
            clr_mask = {NUM_EVENTS{1'b0}};
        end
    end

    // Set on a rising edge (set wins over a same-cycle clear so a retrigger
    // is never lost); an edge on an already pending event is simply absorbed.
    always_comb begin
        req_d     = req_i;
        pending_d = (pending_q & ~clr_mask) | (req_i & ~req_q);
    end

    // Fixed priority: lowest event ID wins.
    always_comb begin
        win_valid_o = |pending_q;
        if (pending_q[0]) begin
            win_id_o = EV_HOLE;
        end else if (pending_q[1]) begin
            win_id_o = EV_BALL;
        end else if (pending_q[2]) begin
            win_id_o = EV_BORDER;
        end else if (pending_q[3]) begin
            win_id_o = EV_ENTER;
        end else if (pending_q[4]) begin
            win_id_o = EV_KEYY;
        end else if (pending_q[5]) begin
            win_id_o = EV_KEYX;
        end else begin
            win_id_o = EV_NONE;
        end
    end

    // Edge and pending registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q     <= {NUM_EVENTS{1'b0}};
            pending_q <= {NUM_EVENTS{1'b0}};
        end else begin
            req_q     <= req_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/sound_sequencer.sv
// sound_sequencer: turns game sound requests into timed note sequences.
//   clk, reset                 : clock, synchronous active-high reset
//   *AudioRequest              : six request lines (level or pulse)
//   tone_idx                   : note code to the tone generator, 0 = silence
//   sound_enable               : high while a note sounds
//   busy                       : high in NOTE or GAP
//   playing_event              : event ID being played, 7 when idle
// All outputs are registered, computed from the next-state values so a note
// appears two cycles after its request rises.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int TICKS_PER_MS = 50000,
    parameter int NOTE_MS      = 80,
    parameter int GAP_MS       = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keyXAudioRequest,
    input  logic       keyYAudioRequest,
    input  logic       keyEnterAudioRequest,
    input  logic       holeColAudioRequest,
    input  logic       borderColAudioRequest,
    input  logic       ballToBallColAudioRequest,
    output logic [3:0] tone_idx,
    output logic       sound_enable,
    output logic       busy,
    output logic [2:0] playing_event
);

    localparam int NOTE_CYC = NOTE_MS * TICKS_PER_MS;
    localparam int GAP_CYC  = GAP_MS * TICKS_PER_MS;
    localparam int MAX_CYC  = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
    localparam int CNT_W    = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    event_e           event_q, event_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       tone_q, tone_d;
    logic             enable_q, enable_d;
    logic             busy_q, busy_d;
    event_e           pev_q, pev_d;

    logic                  load;
    logic                  preempt;
    logic                  win_valid;
    event_e                win_id;
    logic [NUM_EVENTS-1:0] req_vec;

    assign req_vec = {keyXAudioRequest, keyYAudioRequest, keyEnterAudioRequest,
                      borderColAudioRequest, ballToBallColAudioRequest,
                      holeColAudioRequest};

    sound_req_latch u_req_latch (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_vec),
        .clr_i       (load),
        .clr_id_i    (win_id),
        .win_valid_o (win_valid),
        .win_id_o    (win_id)
    );

    // Next-state logic: phase timing, note stepping, loading and preemption.
    always_comb begin
        state_d = state_q;
        event_d = event_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q + CNT_ONE;
        load    = 1'b0;
        // Only a strictly higher-priority (lower ID) event interrupts.
        preempt = win_valid && (win_id < event_q);
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (win_valid) begin
                    load = 1'b1;
                end else begin
                    load = 1'b0;
                end
            end
            ST_NOTE: begin
                if (preempt) begin
                    load = 1'b1;
                end else if (cnt_q == NOTE_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_NOTE;
                end
            end
            ST_GAP: begin
                if (preempt) begin
                    load = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    if ({1'b0, ptr_q} < (note_len(event_q) - 3'd1)) begin
                        ptr_d   = ptr_q + 2'd1;
                        state_d = ST_NOTE;
                        cnt_d   = CNT_ZERO;
                    end else if (win_valid) begin
                        // Chain straight into the next pending jingle.
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        event_d = EV_NONE;
                        ptr_d   = 2'd0;
                        cnt_d   = CNT_ZERO;
                    end
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                event_d = EV_NONE;
                ptr_d   = 2'd0;
                cnt_d   = CNT_ZERO;
            end
        endcase
        if (load) begin
            state_d = ST_NOTE;
            event_d = win_id;
            ptr_d   = 2'd0;
            cnt_d   = CNT_ZERO;
        end else begin
            // Keep the phase decision made above.
        end
    end

    // Output values derived from the next state so they register in step.
    always_comb begin
        enable_d = (state_d == ST_NOTE);
        busy_d   = (state_d != ST_IDLE);
        tone_d   = enable_d ? note_tone(event_d, ptr_d) : TONE_SILENCE;
        pev_d    = event_d;
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            event_q  <= EV_NONE;
            ptr_q    <= 2'd0;
            cnt_q    <= CNT_ZERO;
            tone_q   <= TONE_SILENCE;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            pev_q    <= EV_NONE;
        end else begin
            state_q  <= state_d;
            event_q  <= event_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            tone_q   <= tone_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            pev_q    <= pev_d;
        end
    end

    assign tone_idx      = tone_q;
    assign sound_enable  = enable_q;
    assign busy          = busy_q;
    assign playing_event = pev_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Testbench for sound_sequencer with note=6 cycles, gap=2 cycles.
// Expected notes (event, tone, length) are queued as stimulus is issued; a
// monitor rebuilds each sounded note from the outputs and checks it in order.
module tb_sound_sequencer;

    logic       clk;
    logic       reset;
    logic       keyX, keyY, keyEnter, holeCol, borderCol, ballCol;
    logic [3:0] tone_idx;
    logic       sound_enable;
    logic       busy;
    logic [2:0] playing_event;

    typedef struct packed {
        logic [2:0] ev;
        logic [3:0] tone;
        logic [7:0] len;
    } note_t;

    note_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    sound_sequencer #(
        .TICKS_PER_MS (2),
        .NOTE_MS      (3),
        .GAP_MS       (1)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .keyXAudioRequest          (keyX),
        .keyYAudioRequest          (keyY),
        .keyEnterAudioRequest      (keyEnter),
        .holeColAudioRequest       (holeCol),
        .borderColAudioRequest     (borderCol),
        .ballToBallColAudioRequest (ballCol),
        .tone_idx                  (tone_idx),
        .sound_enable              (sound_enable),
        .busy                      (busy),
        .playing_event             (playing_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_note(input int ev, input int tone, input int len);
        note_t n;
        n.ev   = 3'(ev);
        n.tone = 4'(tone);
        n.len  = 8'(len);
        exp_q.push_back(n);
    endtask

    task automatic close_note(input logic [2:0] ev, input logic [3:0] tone, input int len);
        note_t act;
        note_t exp;
        act.ev   = ev;
        act.tone = tone;
        act.len  = 8'(len);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL note_unexpected: got ev=%0d tone=%0d len=%0d expected no note",
                     act.ev, act.tone, act.len);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL note: got ev=%0d tone=%0d len=%0d expected ev=%0d tone=%0d len=%0d",
                         act.ev, act.tone, act.len, exp.ev, exp.tone, exp.len);
            end
        end
    endtask

    // Monitor: a note is a run of sound_enable=1 with constant tone and event.
    initial begin : monitor
        logic       in_note;
        logic [2:0] cur_ev;
        logic [3:0] cur_tone;
        int         cur_len;
        in_note  = 1'b0;
        cur_ev   = 3'd0;
        cur_tone = 4'd0;
        cur_len  = 0;
        forever begin
            @(negedge clk);
            if (sound_enable === 1'b1 && in_note && tone_idx === cur_tone &&
                playing_event === cur_ev) begin
                cur_len++;
            end else begin
                if (in_note) close_note(cur_ev, cur_tone, cur_len);
                if (sound_enable === 1'b1) begin
                    in_note  = 1'b1;
                    cur_ev   = playing_event;
                    cur_tone = tone_idx;
                    cur_len  = 1;
                end else begin
                    in_note = 1'b0;
                end
            end
        end
    end

    task automatic clear_reqs();
        keyX = 1'b0; keyY = 1'b0; keyEnter = 1'b0;
        holeCol = 1'b0; borderCol = 1'b0; ballCol = 1'b0;
    endtask

    task automatic scen_border(input string tag);
        expect_note(2, 1, 6);
        for (int c = 0; c <= 12; c++) begin
            borderCol = (c == 0);
            if (c == 1) check({tag, "_en_c1"}, sound_enable, 0);
            if (c == 2) begin
                check({tag, "_en_c2"}, sound_enable, 1);
                check({tag, "_tone_c2"}, tone_idx, 1);
                check({tag, "_event_c2"}, playing_event, 2);
            end
            if (c == 7) check({tag, "_en_c7"}, sound_enable, 1);
            if (c == 8) begin
                check({tag, "_en_c8"}, sound_enable, 0);
                check({tag, "_tone_c8"}, tone_idx, 0);
                check({tag, "_busy_c8"}, busy, 1);
            end
            if (c == 10) begin
                check({tag, "_busy_c10"}, busy, 0);
                check({tag, "_event_c10"}, playing_event, 7);
            end
            tick();
        end
    endtask

    initial begin : stimulus
        int busy_cnt;
        reset = 1'b1;
        clear_reqs();
        repeat (3) tick();
        check("rst_tone", tone_idx, 0);
        check("rst_en", sound_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_event", playing_event, 7);
        reset = 1'b0;
        tick();

        // Single border pulse.
        scen_border("border");

        // Hole held high: exactly one jingle, 32 busy cycles.
        expect_note(0, 7, 6); expect_note(0, 9, 6);
        expect_note(0, 10, 6); expect_note(0, 11, 6);
        busy_cnt = 0;
        for (int c = 0; c <= 105; c++) begin
            holeCol = (c < 100);
            if (c >= 1 && busy === 1'b1) busy_cnt++;
            if (c == 2) check("hold_tone_c2", tone_idx, 7);
            tick();
        end
        check("hold_busy_cycles", busy_cnt, 32);
        check("hold_idle_end", busy, 0);

        // keyX and hole together: hole first, keyX chained without idle.
        expect_note(0, 7, 6); expect_note(0, 9, 6);
        expect_note(0, 10, 6); expect_note(0, 11, 6);
        expect_note(5, 2, 6);
        busy_cnt = 0;
        for (int c = 0; c <= 45; c++) begin
            keyX    = (c == 0);
            holeCol = (c == 0);
            if (c >= 2 && c <= 41 && busy === 1'b1) busy_cnt++;
            if (c == 33) check("chain_gap_c33", sound_enable, 0);
            if (c == 34) begin
                check("chain_en_c34", sound_enable, 1);
                check("chain_tone_c34", tone_idx, 2);
                check("chain_event_c34", playing_event, 5);
            end
            if (c == 42) check("chain_idle_c42", busy, 0);
            tick();
        end
        check("chain_busy_cycles", busy_cnt, 40);

        // Enter interrupted during its 2nd note by ball-to-ball.
        expect_note(3, 4, 6); expect_note(3, 6, 4);
        expect_note(1, 5, 6); expect_note(1, 9, 6);
        for (int c = 0; c <= 40; c++) begin
            keyEnter = (c == 0);
            ballCol  = (c == 12);
            if (c == 10) check("pre_enter_tone_c10", tone_idx, 6);
            if (c == 14) begin
                check("pre_event_c14", playing_event, 1);
                check("pre_tone_c14", tone_idx, 5);
            end
            if (c == 30) check("pre_event_c30", playing_event, 7);
            if (c == 40) check("pre_idle_c40", busy, 0);
            tick();
        end

        // keyY retriggered while playing, second rise while pending absorbed.
        expect_note(4, 3, 6); expect_note(4, 3, 6);
        for (int c = 0; c <= 30; c++) begin
            keyY = (c == 0 || c == 4 || c == 6);
            if (c == 8) check("retrig_gap_c8", sound_enable, 0);
            if (c == 10) begin
                check("retrig_en_c10", sound_enable, 1);
                check("retrig_event_c10", playing_event, 4);
            end
            if (c == 18) check("retrig_idle_c18", busy, 0);
            if (c == 30) check("retrig_idle_c30", busy, 0);
            tick();
        end

        // Reset mid-note of hole also drops a pending keyX.
        expect_note(0, 7, 3);
        for (int c = 0; c <= 15; c++) begin
            holeCol = (c == 0);
            keyX    = (c == 3);
            reset   = (c == 4);
            if (c == 3) check("rst_mid_tone_c3", tone_idx, 7);
            if (c == 5) begin
                check("rst_mid_tone_c5", tone_idx, 0);
                check("rst_mid_en_c5", sound_enable, 0);
                check("rst_mid_busy_c5", busy, 0);
                check("rst_mid_event_c5", playing_event, 7);
            end
            if (c == 12) check("rst_mid_idle_c12", busy, 0);
            tick();
        end
        scen_border("post_rst");

        repeat (4) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Consumes the six audio request lines produced by the game's sound request logic: key X, key Y, key Enter, hole collision, border collision and ball-to-ball collision.
- Turns each request into a short timed note sequence, arbitrated by priority.
- Drives a note index and enable into the downstream tone generator / audio codec path.
- Sits between game/collision logic and the audio output, so one request pulse or held level yields exactly one complete jingle.

Parameters:
- TICKS_PER_MS, 50000, clock cycles per millisecond (50 MHz clock).
- NOTE_MS, 80, duration of each note in ms.
- GAP_MS, 10, silence after each note in ms.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- keyXAudioRequest  in  1  key X sound request (level or pulse)
- keyYAudioRequest  in  1  key Y sound request
- keyEnterAudioRequest  in  1  Enter key sound request
- holeColAudioRequest  in  1  ball-in-hole sound request
- borderColAudioRequest  in  1  border hit sound request
- ballToBallColAudioRequest  in  1  ball-to-ball hit sound request
- tone_idx  out  4  note code to the tone generator; 0 = silence
- sound_enable  out  1  high while a note is sounding
- busy  out  1  high in NOTE or GAP
- playing_event  out  3  event ID currently playing; 7 when idle

Behaviour:
- Reset: tone_idx=0, sound_enable=0, busy=0, playing_event=7, all pending bits 0, edge registers 0, state IDLE, counters 0.
- Edge detect: each request input is registered. A 0->1 transition sets that event's pending bit on the next cycle. A held-high level produces one request only.
- Priority, event IDs 0 highest: 0 hole, 1 ball-to-ball, 2 border, 3 enter, 4 keyY, 5 keyX.
- States: IDLE, NOTE, GAP.
- IDLE -> NOTE:
  - Taken when any pending bit is set.
  - Loads the highest-priority pending event, clears its pending bit, note_ptr=0, cycle counter=0.
  - Latency: input rises in cycle 0, pending set in cycle 1, sound_enable=1 with valid tone_idx in cycle 2.
- NOTE:
  - sound_enable=1, tone_idx=table[event][note_ptr].
  - Lasts exactly NOTE_MS*TICKS_PER_MS cycles, then GAP.
- GAP:
  - sound_enable=0, tone_idx=0.
  - Lasts exactly GAP_MS*TICKS_PER_MS cycles.
  - At the end: if note_ptr < len[event]-1, increment note_ptr and go to NOTE.
  - Otherwise go directly to NOTE if another event is pending (loading it as from IDLE), else IDLE.
- Preemption:
  - Checked every cycle in NOTE or GAP.
  - If a pending event has strictly higher priority than playing_event, the next cycle loads it as from IDLE.
  - The interrupted event is dropped, not resumed.
- Retrigger of the playing event: sets its pending bit; it plays again in full after the current sequence ends.
- Simultaneous rising edges: all pending bits set in the same cycle; served in priority order, one sequence after another.
- A rising edge on an event whose pending bit is already set is absorbed; no counting.
- Reset mid-sequence aborts immediately to reset values.
- Counter width: $clog2(max(NOTE_MS,GAP_MS)*TICKS_PER_MS)+1; no wrap inside a phase.

Decomposition:
- Package sound_pkg holds:
  - event ID enum and EV_NONE=7
  - note code constants: 1=C4, 2=D4, 3=E4, 4=G4, 5=A4, 6=B4, 7=C5, 8=D5, 9=E5, 10=G5, 11=C6
  - per-event note table (max 4 notes)
  - length table: hole C5,E5,G5,C6 (4); ball A4,E5 (2); border C4 (1); enter G4,B4,D5 (3); keyY E4 (1); keyX D4 (1)
- Sub-module sound_req_latch: edge detect, pending bits and priority encoder, outputting the winner ID and a valid bit.
- sound_sequencer keeps the FSM, counters and table lookup.

Test Plan (TICKS_PER_MS=2, NOTE_MS=3, GAP_MS=1, so note=6 cycles and gap=2 cycles):
- Border pulse for 1 cycle at cycle 0 -> sound_enable high cycles 2-7 with tone_idx=1, low cycles 8-9, then busy=0 and playing_event=7 at cycle 10.
- Hole held high for 100 cycles -> tone_idx sequence 7,9,10,11, each for 6 cycles with 2-cycle gaps, and exactly one sequence (32 cycles of busy).
- keyX and hole rise in the same cycle -> hole sequence plays first, then keyX (tone 2) starts with no IDLE cycle between.
- Enter playing its 2nd note, ball-to-ball rises -> within 2 cycles playing_event=1 and tone_idx=5; enter does not resume afterwards.
- keyY rises while keyY is playing -> keyY plays twice back-to-back; a second rise during pending adds nothing.
- Reset asserted mid-NOTE of hole -> next cycle all outputs at reset values; a later border pulse behaves as in the first scenario.
